alu_issue_ctrl: RTL and testbench

- Upstream issue controller for the 8-bit registered ALU (CLK/EN/OE/OPCODE/A/B -> ALU_OUT, CF/OF/SF/ZF).
- Accepts a byte-serial command stream over a valid/ready handshake and assembles it into a 3-byte frame: opcode, A, B.
- Issues one single-cycle ALU enable per command, waits the ALU latency, captures the result and flags, and returns them on a valid/ready response port.
- Serialises ALU use: exactly one command in flight.

---
 rtl/alu_issue_ctrl_pkg.sv | 33 +++
 rtl/alu_issue_ctrl.sv | 161 ++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared opcode, flag-index and controller-state definitions for the ALU issue path.
// Opcode legality helper is used when ALU_ILLEGAL_OP_CHECK_EN is defined.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_ADD = 4'b0010,
      OP_SUB = 4'b0011,
      OP_AND = 4'b0100,
      OP_OR  = 4'b0101,
      OP_XOR = 4'b0110,
      OP_NOT = 4'b0111
   } opcode_e;

   localparam int CF_BIT = 3;
   localparam int OF_BIT = 2;
   localparam int SF_BIT = 1;
   localparam int ZF_BIT = 0;

   typedef enum logic [2:0] {
      GET_OP = 3'd0,
      GET_A  = 3'd1,
      GET_B  = 3'd2,
      ISSUE  = 3'd3,
      WAIT   = 3'd4,
      RESP   = 3'd5
   } state_e;

   // Only the low eight opcodes map to real ALU operations.
   function automatic logic is_legal_op(input logic [3:0] op);
      return (op[3] == 1'b0);
   endfunction

endpackage

// File: rtl/alu_issue_ctrl.sv
// Byte-serial command framer and single-in-flight issue controller for the registered ALU.
// Define ALU_ILLEGAL_OP_CHECK_EN to reject opcodes 8..15 with an error response instead of issuing them.
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int ALU_LAT = 1,
   parameter int DW      = 8
)(
   input  logic          CLK,
   input  logic          RST_N,
   input  logic [DW-1:0] IN_DATA,
   input  logic          IN_VALID,
   output logic          IN_READY,
   output logic          ALU_EN,
   output logic          ALU_OE,
   output logic [3:0]    ALU_OPCODE,
   output logic [DW-1:0] ALU_A,
   output logic [DW-1:0] ALU_B,
   input  logic [DW-1:0] ALU_RESULT,
   input  logic [3:0]    ALU_FLAGS,
   output logic [DW-1:0] RES_DATA,
   output logic [3:0]    RES_FLAGS,
   output logic          RES_ERR,
   output logic          RES_VALID,
   input  logic          RES_READY,
   output logic          BUSY
);

   localparam logic [2:0] LAT_INIT = 3'(ALU_LAT);

   state_e        state_r;
   state_e        state_n_s;
   logic [2:0]    cnt_r;
   logic          in_ready_r;
   logic          alu_en_r;
   logic          alu_oe_r;
   logic [3:0]    alu_opcode_r;
   logic [DW-1:0] alu_a_r;
   logic [DW-1:0] alu_b_r;
   logic [DW-1:0] res_data_r;
   logic [3:0]    res_flags_r;
   logic          res_err_r;
   logic          res_valid_r;
   logic          in_fire_s;
   logic          op_ok_s;

   // Byte handshake and opcode screening for the frame being assembled.
   always_comb begin
      in_fire_s = IN_VALID && in_ready_r;
`ifdef ALU_ILLEGAL_OP_CHECK_EN
      op_ok_s = is_legal_op(alu_opcode_r);
`else
      op_ok_s = 1'b1;
`endif
   end

   // Next-state selection for the frame / issue / response sequence.
   always_comb begin
      state_n_s = state_r;
      case (state_r)
         GET_OP: begin
            if (in_fire_s) state_n_s = GET_A;
            else           state_n_s = GET_OP;
         end
         GET_A: begin
            if (in_fire_s) state_n_s = GET_B;
            else           state_n_s = GET_A;
         end
         GET_B: begin
            if (in_fire_s && op_ok_s)  state_n_s = ISSUE;
            else if (in_fire_s)        state_n_s = RESP;
            else                       state_n_s = GET_B;
         end
         ISSUE: state_n_s = WAIT;
         WAIT: begin
            if (cnt_r <= 3'd1) state_n_s = RESP;
            else               state_n_s = WAIT;
         end
         RESP: begin
            if (RES_READY && res_valid_r) state_n_s = GET_OP;
            else                          state_n_s = RESP;
         end
         default: state_n_s = GET_OP;
      endcase
   end

   // State, operand, latency-counter and response registers.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_r      <= GET_OP;
         cnt_r        <= 3'd0;
         in_ready_r   <= 1'b0;
         alu_en_r     <= 1'b0;
         alu_oe_r     <= 1'b0;
         alu_opcode_r <= 4'd0;
         alu_a_r      <= '0;
         alu_b_r      <= '0;
         res_data_r   <= '0;
         res_flags_r  <= 4'd0;
         res_err_r    <= 1'b0;
         res_valid_r  <= 1'b0;
      end else begin
         state_r    <= state_n_s;
         alu_oe_r   <= 1'b1;
         in_ready_r <= (state_n_s == GET_OP) || (state_n_s == GET_A) || (state_n_s == GET_B);
         // The enable pulse spans exactly the ISSUE cycle.
         alu_en_r   <= (state_r == GET_B) && in_fire_s && op_ok_s;
         case (state_r)
            GET_OP: begin
               if (in_fire_s) alu_opcode_r <= IN_DATA[3:0];
            end
            GET_A: begin
               if (in_fire_s) alu_a_r <= IN_DATA;
            end
            GET_B: begin
               if (in_fire_s) begin
                  alu_b_r <= IN_DATA;
                  if (!op_ok_s) begin
                     res_data_r  <= '0;
                     res_flags_r <= 4'd0;
                     res_err_r   <= 1'b1;
                     res_valid_r <= 1'b1;
                  end
               end
            end
            ISSUE: cnt_r <= LAT_INIT;
            WAIT: begin
               if (cnt_r <= 3'd1) begin
                  cnt_r       <= 3'd0;
                  res_data_r  <= ALU_RESULT;
                  res_flags_r <= ALU_FLAGS;
                  res_err_r   <= 1'b0;
                  res_valid_r <= 1'b1;
               end else begin
                  cnt_r <= cnt_r - 3'd1;
               end
            end
            RESP: begin
               if (RES_READY) begin
                  res_valid_r <= 1'b0;
                  res_err_r   <= 1'b0;
               end
            end
            default: cnt_r <= 3'd0;
         endcase
      end
   end

   assign IN_READY   = in_ready_r;
   assign ALU_EN     = alu_en_r;
   assign ALU_OE     = alu_oe_r;
   assign ALU_OPCODE = alu_opcode_r;
   assign ALU_A      = alu_a_r;
   assign ALU_B      = alu_b_r;
   assign RES_DATA   = res_data_r;
   assign RES_FLAGS  = res_flags_r;
   assign RES_ERR    = res_err_r;
   assign RES_VALID  = res_valid_r;
   assign BUSY       = (state_r != GET_OP);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: behavioural ALU in the loop plus a command-level reference model.
// Honours ALU_ILLEGAL_OP_CHECK_EN when the same macro is defined for the bench build.
module tb_alu_issue_ctrl;
   localparam int LAT = 1;

   logic       CLK = 1'b0;
   logic       RST_N = 1'b0;
   logic [7:0] IN_DATA = 8'h00;
   logic       IN_VALID = 1'b0;
   logic       IN_READY;
   logic       ALU_EN, ALU_OE;
   logic [3:0] ALU_OPCODE;
   logic [7:0] ALU_A, ALU_B;
   logic [7:0] ALU_RESULT = 8'h00;
   logic [3:0] ALU_FLAGS = 4'h0;
   logic [7:0] RES_DATA;
   logic [3:0] RES_FLAGS;
   logic       RES_ERR, RES_VALID;
   logic       RES_READY = 1'b0;
   logic       BUSY;

   int vectors = 0;
   int miscompares = 0;
   int en_count = 0;

   alu_issue_ctrl #(.ALU_LAT(LAT), .DW(8)) dut (
      .CLK(CLK), .RST_N(RST_N), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
      .ALU_EN(ALU_EN), .ALU_OE(ALU_OE), .ALU_OPCODE(ALU_OPCODE), .ALU_A(ALU_A), .ALU_B(ALU_B),
      .ALU_RESULT(ALU_RESULT), .ALU_FLAGS(ALU_FLAGS), .RES_DATA(RES_DATA), .RES_FLAGS(RES_FLAGS),
      .RES_ERR(RES_ERR), .RES_VALID(RES_VALID), .RES_READY(RES_READY), .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   // Reference ALU behaviour: returns {CF,OF,SF,ZF,result}.
   function automatic logic [11:0] alu_ref(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      logic [8:0] w;
      logic [7:0] r;
      logic c, o;
      c = 1'b0; o = 1'b0; w = 9'd0;
      case (op)
         4'd2: begin w = {1'b0, a} + {1'b0, b}; r = w[7:0]; c = w[8]; o = (a[7] == b[7]) && (r[7] != a[7]); end
         4'd3: begin w = {1'b0, a} - {1'b0, b}; r = w[7:0]; c = w[8]; o = (a[7] != b[7]) && (r[7] != a[7]); end
         4'd4: r = a & b;
         4'd5: r = a | b;
         4'd6: r = a ^ b;
         4'd7: r = ~a;
         4'd1: r = b;
         default: r = a;
      endcase
      return {c, o, r[7], (r == 8'd0), r};
   endfunction

   // ALU in the loop: result valid only in the cycle after the enable edge, noise otherwise.
   always @(posedge CLK) begin
      if (ALU_EN) begin
         {ALU_FLAGS, ALU_RESULT} <= alu_ref(ALU_OPCODE, ALU_A, ALU_B);
         en_count <= en_count + 1;
      end else begin
         {ALU_FLAGS, ALU_RESULT} <= 12'($urandom);
      end
   end

   task automatic send_byte(input logic [7:0] b, input int gap);
      int t;
      IN_VALID = 1'b0;
      repeat (gap) begin IN_DATA = 8'($urandom); @(posedge CLK); #1; end
      IN_VALID = 1'b1;
      IN_DATA = b;
      t = 0;
      while (!IN_READY && t < 20) begin @(posedge CLK); #1; t++; end
      vectors++;
      if (IN_READY !== 1'b1) begin
         miscompares++;
         $display("FAIL in_ready_timeout: IN_READY=%b required 1", IN_READY);
      end
      @(posedge CLK); #1;
      IN_VALID = 1'b1;
      IN_DATA = 8'($urandom);
   endtask

   task automatic do_cmd(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                         input int gap, input int hold, input string name);
      logic [11:0] exp;
      logic        exp_err;
      int          en0, lat, exp_lat, bad;
      logic [12:0] snap;
      exp = alu_ref(op[3:0], a, b);
      exp_err = 1'b0;
`ifdef ALU_ILLEGAL_OP_CHECK_EN
      if (op[3]) begin exp_err = 1'b1; exp = 12'h000; end
`endif
      exp_lat = exp_err ? 0 : 1 + LAT;
      RES_READY = (hold == 0);
      en0 = en_count;
      send_byte(op, gap);
      send_byte(a, gap);
      send_byte(b, gap);
      lat = 0; bad = 0;
      while (!RES_VALID && lat < 40) begin
         if (IN_READY !== 1'b0) bad++;
         @(posedge CLK); #1; lat++;
      end
      vectors++;
      if (lat != exp_lat) begin
         miscompares++;
         $display("FAIL %s latency: got %0d edges required %0d", name, lat, exp_lat);
      end
      vectors++;
      if ({RES_ERR, RES_FLAGS, RES_DATA} !== {exp_err, exp}) begin
         miscompares++;
         $display("FAIL %s response: err/flags/data=%b/%b/%h required %b/%b/%h",
                  name, RES_ERR, RES_FLAGS, RES_DATA, exp_err, exp[11:8], exp[7:0]);
      end
      snap = {RES_ERR, RES_FLAGS, RES_DATA};
      for (int i = 0; i < hold; i++) begin
         if (IN_READY !== 1'b0) bad++;
         @(posedge CLK); #1;
         if (RES_VALID !== 1'b1 || {RES_ERR, RES_FLAGS, RES_DATA} !== snap || IN_READY !== 1'b0) bad++;
      end
      if (IN_READY !== 1'b0) bad++;
      RES_READY = 1'b1;
      @(posedge CLK); #1;
      IN_VALID = 1'b0;
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL %s backpressure/hold: %0d violating cycles required 0", name, bad);
      end
      vectors++;
      if ({RES_VALID, RES_ERR, IN_READY} !== 3'b001) begin
         miscompares++;
         $display("FAIL %s handshake: valid/err/in_ready=%b%b%b required 001", name, RES_VALID, RES_ERR, IN_READY);
      end
      vectors++;
      if (en_count - en0 != (exp_err ? 0 : 1)) begin
         miscompares++;
         $display("FAIL %s alu_en_pulses: got %0d required %0d", name, en_count - en0, exp_err ? 0 : 1);
      end
   endtask

   task automatic check_all_zero(input string name);
      vectors++;
      if ({IN_READY, ALU_EN, ALU_OE, RES_VALID, RES_ERR, ALU_OPCODE, ALU_A, ALU_B, RES_DATA, RES_FLAGS} !== 41'd0) begin
         miscompares++;
         $display("FAIL %s outputs_zero: rdy=%b en=%b oe=%b v=%b e=%b op=%h a=%h b=%h d=%h f=%h required all 0",
                  name, IN_READY, ALU_EN, ALU_OE, RES_VALID, RES_ERR, ALU_OPCODE, ALU_A, ALU_B, RES_DATA, RES_FLAGS);
      end
   endtask

   task automatic check_after_release(input string name);
      #4 RST_N = 1'b1;
      @(posedge CLK); #1;
      vectors++;
      if ({ALU_OE, IN_READY, RES_VALID, BUSY} !== 4'b1100) begin
         miscompares++;
         $display("FAIL %s release: oe/rdy/valid/busy=%b%b%b%b required 1100", name, ALU_OE, IN_READY, RES_VALID, BUSY);
      end
   endtask

   task automatic test_reset();
      RST_N = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      check_all_zero("reset");
      check_after_release("reset");
   endtask

   task automatic test_directed();
      do_cmd(8'h02, 8'hFF, 8'hFF, 0, 0, "add_ff_ff");
      do_cmd(8'h02, 8'h67, 8'h1E, 0, 0, "add_ovf");
      do_cmd(8'h06, 8'h00, 8'h00, 0, 0, "xor_zero");
   endtask

   task automatic test_stall();
      do_cmd(8'h03, 8'h16, 8'hF5, 0, 10, "sub_stall");
   endtask

   task automatic test_gaps();
      do_cmd(8'h05, 8'h0F, 8'hF0, 3, 0, "or_gaps");
   endtask

   task automatic test_reset_mid();
      int en0;
      RES_READY = 1'b1;
      send_byte(8'h04, 0);
      send_byte(8'hAA, 0);
      send_byte(8'h55, 0);
      IN_VALID = 1'b0;
      @(posedge CLK); #3;
      RST_N = 1'b0;
      #1;
      check_all_zero("reset_mid");
      en0 = en_count;
      @(posedge CLK); #1;
      check_after_release("reset_mid");
      repeat (5) @(posedge CLK);
      #1;
      vectors++;
      if (en_count != en0 || RES_VALID !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid no_reissue: en pulses=%0d valid=%b required 0/0", en_count - en0, RES_VALID);
      end
      do_cmd(8'h04, 8'hF0, 8'h3C, 0, 0, "and_after_reset");
   endtask

   task automatic test_illegal_op();
      do_cmd(8'h09, 8'h12, 8'h34, 0, 0, "op_09");
   endtask

   task automatic test_random();
      for (int i = 0; i < 30; i++) begin
         do_cmd(8'($urandom), 8'($urandom), 8'($urandom),
                int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), "random");
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_stall();
      test_gaps();
      test_reset_mid();
      test_illegal_op();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
